// File: rtl/sdram_device_model.sv
// Behavioural single-chip 16-bit SDR SDRAM responder: decodes pin commands, tracks
// open rows and the mode register, serves reads/writes and latches protocol violations.
module sdram_device_model #(
    parameter int MEM_AW    = 16,
    parameter int TRCD_CYC  = 1,
    parameter int INIT_NOPS = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic        err,
    output logic [3:0]  err_code,
    output logic [15:0] refresh_count
);

    localparam logic [2:0] CMD_LMR = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_BST = 3'b110;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam logic [3:0] ERR_NONE     = 4'd0;
    localparam logic [3:0] ERR_CL       = 4'd1;
    localparam logic [3:0] ERR_BL       = 4'd2;
    localparam logic [3:0] ERR_LMR_OPEN = 4'd3;
    localparam logic [3:0] ERR_ACT_OPEN = 4'd4;
    localparam logic [3:0] ERR_REF_OPEN = 4'd5;
    localparam logic [3:0] ERR_NO_MODE  = 4'd6;
    localparam logic [3:0] ERR_CLOSED   = 4'd7;
    localparam logic [3:0] ERR_TRCD     = 4'd8;
    localparam logic [3:0] ERR_CONTEND  = 4'd9;
    localparam logic [3:0] ERR_INIT     = 4'd10;

    localparam logic [7:0]  TRCD_LIM = 8'(TRCD_CYC);
    localparam logic [15:0] INIT_LIM = 16'(INIT_NOPS);

    logic [15:0] mem_r [0:(2**MEM_AW)-1];
    logic [3:0]  bank_open_r;
    logic [12:0] bank_row_r [4];
    logic [7:0]  since_act_r [4];
    logic        mode_loaded_r;
    logic [2:0]  cl_r;
    logic [15:0] init_cnt_r;
    logic [1:0]  pipe_v_r;
    logic [15:0] pipe_d_r [2];

    logic [2:0]        cmd_s;
    logic              nop_s;
    logic [23:0]       full_addr_s;
    logic [MEM_AW-1:0] addr_s;
    logic              out_v_s;
    logic [15:0]       out_d_s;
    logic [3:0]        viol_s;
    logic              do_lmr_s;
    logic              do_act_s;
    logic              do_pre_s;
    logic              do_ref_s;
    logic              do_wr_s;
    logic              do_rd_s;

    assign cmd_s       = {sdram_nras, sdram_ncas, sdram_nwe};
    assign nop_s       = sdram_ncs || (cmd_s == CMD_NOP) || (cmd_s == CMD_BST);
    assign full_addr_s = {sdram_ba, bank_row_r[sdram_ba], sdram_a[8:0]};
    assign addr_s      = MEM_AW'(full_addr_s);
    assign out_v_s     = (cl_r == 3'd3) ? pipe_v_r[1] : pipe_v_r[0];
    assign out_d_s     = (cl_r == 3'd3) ? pipe_d_r[1] : pipe_d_r[0];

    // Command decode: classify the sampled command and pick its highest-priority violation.
    always_comb begin
        viol_s   = ERR_NONE;
        do_lmr_s = 1'b0;
        do_act_s = 1'b0;
        do_pre_s = 1'b0;
        do_ref_s = 1'b0;
        do_wr_s  = 1'b0;
        do_rd_s  = 1'b0;
        if (!nop_s && (init_cnt_r < INIT_LIM)) begin
            viol_s = ERR_INIT;
        end else if (!nop_s) begin
            case (cmd_s)
                CMD_LMR: begin
                    do_lmr_s = 1'b1;
                    if ((sdram_a[6:4] != 3'd2) && (sdram_a[6:4] != 3'd3)) begin
                        viol_s = ERR_CL;
                    end else if (sdram_a[2:0] != 3'd0) begin
                        viol_s = ERR_BL;
                    end else if (|bank_open_r) begin
                        viol_s = ERR_LMR_OPEN;
                    end else begin
                        viol_s = ERR_NONE;
                    end
                end
                CMD_ACT: begin
                    if (bank_open_r[sdram_ba]) begin
                        viol_s = ERR_ACT_OPEN;
                    end else begin
                        do_act_s = 1'b1;
                    end
                end
                CMD_PRE: begin
                    do_pre_s = 1'b1;
                end
                CMD_REF: begin
                    do_ref_s = 1'b1;
                    if (|bank_open_r) begin
                        viol_s = ERR_REF_OPEN;
                    end else begin
                        viol_s = ERR_NONE;
                    end
                end
                CMD_WR, CMD_RD: begin
                    if (!mode_loaded_r) begin
                        viol_s = ERR_NO_MODE;
                    end else if (!bank_open_r[sdram_ba]) begin
                        viol_s = ERR_CLOSED;
                    end else if (since_act_r[sdram_ba] < TRCD_LIM) begin
                        viol_s = ERR_TRCD;
                    end else if (cmd_s == CMD_WR) begin
                        // Contention is reported but the write is still committed.
                        do_wr_s = 1'b1;
                        if (dq_oe) begin
                            viol_s = ERR_CONTEND;
                        end else begin
                            viol_s = ERR_NONE;
                        end
                    end else begin
                        do_rd_s = 1'b1;
                    end
                end
                default: begin
                    viol_s = ERR_NONE;
                end
            endcase
        end else begin
            viol_s = ERR_NONE;
        end
    end

    // Backing array: survives reset, byte lanes written unless masked.
    always_ff @(posedge clk) begin
        if (!reset && do_wr_s) begin
            if (!sdram_dqml) begin
                mem_r[addr_s][7:0] <= dq_i[7:0];
            end
            if (!sdram_dqmh) begin
                mem_r[addr_s][15:8] <= dq_i[15:8];
            end
        end
    end

    // Bank, mode, read pipeline, refresh and error state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_open_r   <= 4'd0;
            mode_loaded_r <= 1'b0;
            cl_r          <= 3'd0;
            init_cnt_r    <= 16'd0;
            pipe_v_r      <= 2'd0;
            pipe_d_r[0]   <= 16'd0;
            pipe_d_r[1]   <= 16'd0;
            dq_o          <= 16'd0;
            dq_oe         <= 1'b0;
            err           <= 1'b0;
            err_code      <= 4'd0;
            refresh_count <= 16'd0;
            for (int b = 0; b < 4; b++) begin
                bank_row_r[b]  <= 13'd0;
                since_act_r[b] <= 8'd0;
            end
        end else begin
            if (init_cnt_r != 16'hFFFF) begin
                init_cnt_r <= init_cnt_r + 16'd1;
            end
            for (int b = 0; b < 4; b++) begin
                if (do_act_s && (sdram_ba == 2'(b))) begin
                    since_act_r[b] <= 8'd1;
                end else if (since_act_r[b] != 8'hFF) begin
                    since_act_r[b] <= since_act_r[b] + 8'd1;
                end
            end

            if (do_act_s) begin
                bank_open_r[sdram_ba] <= 1'b1;
                bank_row_r[sdram_ba]  <= sdram_a;
            end else if (do_pre_s) begin
                if (sdram_a[10]) begin
                    bank_open_r <= 4'd0;
                end else begin
                    bank_open_r[sdram_ba] <= 1'b0;
                end
            end else if ((do_rd_s || do_wr_s) && sdram_a[10]) begin
                bank_open_r[sdram_ba] <= 1'b0;
            end

            if (do_lmr_s) begin
                mode_loaded_r <= 1'b1;
                cl_r          <= sdram_a[6:4];
            end
            if (do_ref_s) begin
                refresh_count <= refresh_count + 16'd1;
            end

            // Stage 0 captures at the command edge; CL selects where the output taps in.
            pipe_v_r    <= {pipe_v_r[0], do_rd_s};
            pipe_d_r[0] <= mem_r[addr_s];
            pipe_d_r[1] <= pipe_d_r[0];
            dq_oe       <= out_v_s;
            if (out_v_s) begin
                dq_o <= out_d_s;
            end

            if (viol_s != ERR_NONE) begin
                err <= 1'b1;
                if (!err) begin
                    err_code <= viol_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: init, write/read, byte masks, streaming,
// auto-precharge, tRCD, contention, reset flush and mode checks.
module tb_sdram_device_model;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] sdram_a = 13'd0;
    logic [1:0]  sdram_ba = 2'd0;
    logic        sdram_ncs = 1'b1;
    logic        sdram_nras = 1'b1;
    logic        sdram_ncas = 1'b1;
    logic        sdram_nwe = 1'b1;
    logic        sdram_dqml = 1'b0;
    logic        sdram_dqmh = 1'b0;
    logic [15:0] dq_i = 16'd0;
    logic [15:0] dq_o;
    logic        dq_oe;
    logic        err;
    logic [3:0]  err_code;
    logic [15:0] refresh_count;

    int n_checks = 0;
    int n_fail = 0;

    sdram_device_model #(.MEM_AW(16), .TRCD_CYC(2), .INIT_NOPS(2)) dut (
        .clk(clk), .reset(reset), .sdram_a(sdram_a), .sdram_ba(sdram_ba),
        .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras), .sdram_ncas(sdram_ncas),
        .sdram_nwe(sdram_nwe), .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh),
        .dq_i(dq_i), .dq_o(dq_o), .dq_oe(dq_oe), .err(err), .err_code(err_code),
        .refresh_count(refresh_count)
    );

    always #5 clk = ~clk;

    task automatic nop();
        sdram_ncs = 1'b1;
        {sdram_nras, sdram_ncas, sdram_nwe} = 3'b111;
        sdram_dqml = 1'b0;
        sdram_dqmh = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic mh, input logic ml);
        sdram_ncs = 1'b0;
        {sdram_nras, sdram_ncas, sdram_nwe} = c;
        sdram_ba = ba;
        sdram_a = a;
        dq_i = d;
        sdram_dqmh = mh;
        sdram_dqml = ml;
        @(posedge clk);
        #1;
        sdram_ncs = 1'b1;
        {sdram_nras, sdram_ncas, sdram_nwe} = 3'b111;
        sdram_dqml = 1'b0;
        sdram_dqmh = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        nop();
        nop();
        reset = 1'b0;
    endtask

    task automatic init_seq();
        issue(C_PRE, 2'd0, 13'h0400, 16'h0000, 1'b0, 1'b0);
        issue(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
        issue(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
        issue(C_LMR, 2'd0, 13'h0220, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe: got %0b want 0", dq_oe); end
        n_checks++; if (dq_o !== 16'h0000) begin n_fail++; $display("FAIL reset_dq_o: got %h want 0000", dq_o); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
        n_checks++; if (err_code !== 4'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        n_checks++; if (refresh_count !== 16'd0) begin n_fail++; $display("FAIL reset_refresh: got %0d want 0", refresh_count); end
    endtask

    task automatic test_init_guard();
        issue(C_PRE, 2'd0, 13'h0400, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL init_guard_err: got %0b want 1", err); end
        n_checks++; if (err_code !== 4'd10) begin n_fail++; $display("FAIL init_guard_code: got %0d want 10", err_code); end
    endtask

    task automatic test_init();
        apply_reset();
        nop();
        nop();
        init_seq();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL init_err: got %0b want 0", err); end
        n_checks++; if (refresh_count !== 16'd2) begin n_fail++; $display("FAIL init_refresh: got %0d want 2", refresh_count); end
    endtask

    task automatic test_write_read();
        issue(C_ACT, 2'd1, 13'h0123, 16'h0000, 1'b0, 1'b0);
        nop();
        issue(C_WR, 2'd1, 13'h0045, 16'hBEEF, 1'b0, 1'b0);
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL wr_rd_early_oe: got %0b want 0", dq_oe); end
        nop();
        n_checks++; if (dq_oe !== 1'b1) begin n_fail++; $display("FAIL wr_rd_oe: got %0b want 1", dq_oe); end
        n_checks++; if (dq_o !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_data: got %h want beef", dq_o); end
        nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL wr_rd_oe_drop: got %0b want 0", dq_oe); end
    endtask

    task automatic test_byte_write();
        issue(C_WR, 2'd1, 13'h0045, 16'h1234, 1'b1, 1'b0);
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        nop();
        n_checks++; if (dq_o !== 16'hBE34) begin n_fail++; $display("FAIL byte_mask_hi: got %h want be34", dq_o); end
        nop();
        issue(C_WR, 2'd1, 13'h0045, 16'hFFFF, 1'b1, 1'b1);
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b1, 1'b1);
        nop();
        n_checks++; if (dq_o !== 16'hBE34) begin n_fail++; $display("FAIL byte_mask_both: got %h want be34", dq_o); end
        n_checks++; if (dq_oe !== 1'b1) begin n_fail++; $display("FAIL byte_mask_oe: got %0b want 1", dq_oe); end
        nop();
    endtask

    task automatic test_back_to_back();
        issue(C_WR, 2'd1, 13'h0046, 16'hCAFE, 1'b0, 1'b0);
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        issue(C_RD, 2'd1, 13'h0046, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (dq_oe !== 1'b1 || dq_o !== 16'hBE34) begin n_fail++; $display("FAIL b2b_first: got oe=%0b %h want oe=1 be34", dq_oe, dq_o); end
        nop();
        n_checks++; if (dq_oe !== 1'b1 || dq_o !== 16'hCAFE) begin n_fail++; $display("FAIL b2b_second: got oe=%0b %h want oe=1 cafe", dq_oe, dq_o); end
        nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL b2b_end_oe: got %0b want 0", dq_oe); end
    endtask

    task automatic test_autoprecharge();
        issue(C_RD, 2'd1, 13'h0445, 16'h0000, 1'b0, 1'b0);
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd7) begin n_fail++; $display("FAIL ap_err: got err=%0b code=%0d want err=1 code=7", err, err_code); end
        n_checks++; if (dq_oe !== 1'b1 || dq_o !== 16'hBE34) begin n_fail++; $display("FAIL ap_first_read: got oe=%0b %h want oe=1 be34", dq_oe, dq_o); end
        nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL ap_no_second_pulse: got %0b want 0", dq_oe); end
    endtask

    task automatic test_trcd();
        apply_reset();
        nop();
        nop();
        init_seq();
        issue(C_ACT, 2'd2, 13'h0005, 16'h0000, 1'b0, 1'b0);
        issue(C_RD, 2'd2, 13'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (err_code !== 4'd8) begin n_fail++; $display("FAIL trcd_code: got %0d want 8", err_code); end
        nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL trcd_dropped: got %0b want 0", dq_oe); end
        issue(C_REF, 2'd0, 13'h0000, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd8) begin n_fail++; $display("FAIL first_violation_kept: got err=%0b code=%0d want err=1 code=8", err, err_code); end
    endtask

    task automatic test_reset_flush();
        issue(C_ACT, 2'd1, 13'h0123, 16'h0000, 1'b0, 1'b0);
        nop();
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        reset = 1'b1;
        nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL flush_oe: got %0b want 0", dq_oe); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %0b want 0", err); end
        nop();
        reset = 1'b0;
        nop();
        nop();
        n_checks++; if (dq_oe !== 1'b0) begin n_fail++; $display("FAIL flush_oe_later: got %0b want 0", dq_oe); end
        init_seq();
        issue(C_ACT, 2'd1, 13'h0123, 16'h0000, 1'b0, 1'b0);
        nop();
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        nop();
        n_checks++; if (dq_oe !== 1'b1 || dq_o !== 16'hBE34) begin n_fail++; $display("FAIL preserved_data: got oe=%0b %h want oe=1 be34", dq_oe, dq_o); end
    endtask

    task automatic test_contention();
        nop();
        issue(C_RD, 2'd1, 13'h0045, 16'h0000, 1'b0, 1'b0);
        nop();
        issue(C_WR, 2'd1, 13'h0047, 16'h5A5A, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd9) begin n_fail++; $display("FAIL contention_code: got err=%0b code=%0d want err=1 code=9", err, err_code); end
        issue(C_RD, 2'd1, 13'h0047, 16'h0000, 1'b0, 1'b0);
        nop();
        n_checks++; if (dq_oe !== 1'b1 || dq_o !== 16'h5A5A) begin n_fail++; $display("FAIL contention_commit: got oe=%0b %h want oe=1 5a5a", dq_oe, dq_o); end
    endtask

    task automatic test_bad_mode();
        apply_reset();
        nop();
        nop();
        issue(C_LMR, 2'd0, 13'h0050, 16'h0000, 1'b0, 1'b0);
        n_checks++; if (err !== 1'b1 || err_code !== 4'd1) begin n_fail++; $display("FAIL bad_cl: got err=%0b code=%0d want err=1 code=1", err, err_code); end
    endtask

    initial begin
        test_reset();
        test_init_guard();
        test_init();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_autoprecharge();
        test_trcd();
        test_reset_flush();
        test_contention();
        test_bad_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
